// File: rtl/ahb_master_pkg.sv
// Shared AHB-Lite codes, FSM state encoding and the transfer alignment check
// used by the command-driven AHB master.
package ahb_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Size code 3 is not a legal request for this master, so it never aligns.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE[1:0]: ok = 1'b1;
      HSIZE_HALF[1:0]: ok = ~addr_lo[0];
      HSIZE_WORD[1:0]: ok = (addr_lo == 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master driven by a command/response handshake.
// Optional data-phase wait-state timeout is enabled with `define AHBM_TIMEOUT_EN.
module ahb_cmd_master
  import ahb_master_pkg::*;
#(
  parameter int         AWIDTH    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter int         TIMEOUT   = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [AWIDTH-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [31:0]         hwdata_q, hwdata_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

`ifdef AHBM_TIMEOUT_EN
  logic [15:0]         tcnt_q, tcnt_d;
  logic                rsp_timeout_q, rsp_timeout_d;
`else
  logic [15:0]         timeout_unused;
  assign timeout_unused = TIMEOUT_LAST;
`endif

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef AHBM_TIMEOUT_EN
    tcnt_d        = tcnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wdata_d = cmd_wdata;
          if (is_aligned(cmd_size, cmd_addr[1:0])) begin
            state_d  = ST_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hsize_d  = {1'b0, cmd_size};
          end else begin
            // Rejected locally: the bus never sees this command.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hwdata_d = hwrite_q ? wdata_q : 32'h0;
`ifdef AHBM_TIMEOUT_EN
          tcnt_d = '0;
`endif
        end
      end

      ST_DATA: begin
        if (HREADY) begin
          state_d     = ST_RESP;
          hwdata_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = HRESP;
          rsp_rdata_d = (!hwrite_q && !HRESP) ? HRDATA : 32'h0;
        end else begin
`ifdef AHBM_TIMEOUT_EN
          if (tcnt_q == TIMEOUT_LAST) begin
            state_d       = ST_RESP;
            hwdata_d      = '0;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
`endif
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
`ifdef AHBM_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered so cmd_ready stays low in the first cycle out of reset.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef AHBM_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tcnt_q        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tcnt_q        <= tcnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Self-checking bench for ahb_cmd_master: directed table, reset/timeout
// sequences and randomized commands against a transaction-level model.
module tb_ahb_cmd_master;

`ifdef AHBM_TIMEOUT_EN
  localparam bit TO_EN      = 1'b1;
  localparam int TB_TIMEOUT = 4;
`else
  localparam bit TO_EN      = 1'b0;
  localparam int TB_TIMEOUT = 256;
`endif

  logic        HCLK, HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_cmd_master #(.AWIDTH(32), .HPROT_VAL(4'b0011), .TIMEOUT(TB_TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  logic        r_err, r_to;
  logic [31:0] r_rdata;
  int          r_lat, r_nonseq, r_bad;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] wd;
    int          aw;
    int          dw;
    logic        serr;
    logic [31:0] rd;
    int          rdly;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nonseq;
  } vec_t;

  typedef struct {
    logic        err;
    logic        to;
    logic [31:0] rdata;
    int          lat;
    int          nonseq;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: what the requester should see for one command.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                 input int aw, input int dw, input logic serr, input logic [31:0] rd);
    exp_t e;
    bit aligned;
    aligned = (sz != 2'd3) && ((a % (32'd1 << sz)) == 0);
    e.to = 1'b0;
    if (!aligned) begin
      e.err = 1'b1; e.rdata = 0; e.lat = 1; e.nonseq = 0;
    end else if (TO_EN && dw >= TB_TIMEOUT) begin
      e.err = 1'b1; e.to = 1'b1; e.rdata = 0; e.lat = 2 + aw + TB_TIMEOUT; e.nonseq = aw + 1;
    end else begin
      e.err = serr; e.rdata = (!w && !serr) ? rd : 32'h0; e.lat = 3 + aw + dw; e.nonseq = aw + 1;
    end
    return e;
  endfunction

  task automatic apply_reset();
    HRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_size  = 2'($urandom_range(0, 3));
    cmd_wdata = $urandom;
  endtask

  // Issue one command and play the slave; called and returns on a negedge.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input int aw, input int dw, input logic serr,
                        input logic [31:0] rd, input int rdly, input bit junk);
    int k, awl, dwl, phase;
    r_bad = 0; r_nonseq = 0; r_lat = 0; r_err = 1'b0; r_to = 1'b0; r_rdata = '0;
    txn_no++;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0; rsp_ready = 1'b0;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge HCLK);
      k++;
    end
    if (!cmd_ready) begin
      chk("accept", 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
      apply_reset();
      return;
    end
    @(negedge HCLK);
    cmd_valid = 1'b0;
    awl = aw; dwl = dw; phase = 0; k = 1;
    while (k < 400) begin
      if (rsp_valid) break;
      if (cmd_ready) r_bad++;
      HRDATA = $urandom;
      if (phase == 0) begin
        if (HTRANS == 2'b10) begin
          r_nonseq++;
          if (HADDR !== a || HWRITE !== w || HSIZE !== {1'b0, sz} || HBURST !== 3'b000 ||
              HMASTLOCK !== 1'b0 || HPROT !== 4'b0011) r_bad++;
          if (awl > 0) begin HREADY = 1'b0; awl--; end
          else begin HREADY = 1'b1; phase = 1; end
        end else if (HTRANS !== 2'b00) r_bad++;
      end else if (phase == 1) begin
        if (HTRANS !== 2'b00 || !busy) r_bad++;
        if (HWDATA !== (w ? wd : 32'h0)) r_bad++;
        if (dwl > 0) begin
          HREADY = 1'b0; HRESP = serr && (dwl == 1); dwl--;
        end else begin
          HREADY = 1'b1; HRESP = serr; HRDATA = rd; phase = 2;
        end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
        if (HTRANS !== 2'b00) r_bad++;
      end
      if (junk) begin
        junk_cmd();
        rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge HCLK);
      k++;
    end
    if (!rsp_valid) begin
      chk("rsp_wait", 32'(rsp_valid), 1);
      apply_reset();
      return;
    end
    r_lat = k; r_err = rsp_err; r_rdata = rsp_rdata; r_to = rsp_timeout;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0BAD0;
    for (int d = 0; d < rdly; d++) begin
      rsp_ready = 1'b0;
      if (junk) junk_cmd();
      @(negedge HCLK);
      if (!rsp_valid || rsp_err !== r_err || rsp_rdata !== r_rdata || rsp_timeout !== r_to ||
          cmd_ready || HTRANS !== 2'b00) r_bad++;
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    chk("rsp_clear", {29'b0, rsp_valid, cmd_ready, busy}, 32'b010);
    $display("txn %0d %s addr=%08h size=%0d -> err=%0b to=%0b rdata=%08h lat=%0d nonseq=%0d",
             txn_no, w ? "WR" : "RD", a, sz, r_err, r_to, r_rdata, r_lat, r_nonseq);
  endtask

  vec_t tbl[10];
  exp_t e;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h100, 2'd2, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0,        0, 1'b0, 32'h0,        3, 1};
    tbl[1] = '{1'b0, 32'h104, 2'd2, 32'h0,        0, 3, 1'b0, 32'h12345678, 0, 1'b0, 32'h12345678, 6, 1};
    tbl[2] = '{1'b0, 32'h108, 2'd2, 32'h0,        0, 1, 1'b1, 32'hAAAA5555, 0, 1'b1, 32'h0,        4, 1};
    tbl[3] = '{1'b1, 32'h101, 2'd1, 32'h0000BEEF, 0, 0, 1'b0, 32'h0,        0, 1'b1, 32'h0,        1, 0};
    tbl[4] = '{1'b0, 32'h200, 2'd3, 32'h0,        0, 0, 1'b0, 32'h11111111, 0, 1'b1, 32'h0,        1, 0};
    tbl[5] = '{1'b0, 32'h103, 2'd0, 32'h0,        2, 0, 1'b0, 32'h11223344, 0, 1'b0, 32'h11223344, 5, 3};
    tbl[6] = '{1'b1, 32'h102, 2'd2, 32'h01020304, 0, 0, 1'b0, 32'h0,        0, 1'b1, 32'h0,        1, 0};
    tbl[7] = '{1'b1, 32'h102, 2'd1, 32'h12340000, 0, 2, 1'b0, 32'h0,        0, 1'b0, 32'h0,        5, 1};
    tbl[8] = '{1'b1, 32'h10C, 2'd2, 32'h0F0F0F0F, 1, 2, 1'b1, 32'h0,        0, 1'b1, 32'h0,        6, 2};
    tbl[9] = '{1'b0, 32'h110, 2'd2, 32'h0,        0, 0, 1'b0, 32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 3, 1};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);

    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hsize", 32'(HSIZE), 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("const_bus", {21'b0, HBURST, HMASTLOCK, HPROT, 3'b0}, {21'b0, 3'b000, 1'b0, 4'b0011, 3'b0});
    HRESET = 1'b0;
    @(negedge HCLK);

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, tbl[i].aw, tbl[i].dw, tbl[i].serr,
             tbl[i].rd, tbl[i].rdly, i[0]);
      chk($sformatf("tbl%0d_err", i), 32'(r_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_rdata", i), r_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_to", i), 32'(r_to), 0);
      chk($sformatf("tbl%0d_lat", i), r_lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_nonseq", i), r_nonseq, tbl[i].exp_nonseq);
      chk($sformatf("tbl%0d_bus", i), r_bad, 0);
    end

    // Reset while waiting in the data phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_size = 2'd2;
    cmd_wdata = 32'h5A5A5A5A; HREADY = 1'b1;
    chk("seq_ready", 32'(cmd_ready), 1);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    chk("seq_nonseq", 32'(HTRANS), 2);
    @(negedge HCLK);
    chk("seq_data_htrans", 32'(HTRANS), 0);
    chk("seq_data_hwdata", HWDATA, 32'h5A5A5A5A);
    HREADY = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("midrst_htrans", 32'(HTRANS), 0);
    chk("midrst_state", {29'b0, rsp_valid, busy, 1'b0}, 0);
    chk("midrst_hwdata", HWDATA, 0);
    HRESET = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);

    // Reset while a rejected command's response is pending.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h500; cmd_size = 2'd3;
    for (int i = 0; i < 5 && !cmd_ready; i++) @(negedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    chk("pend_rsp", {30'b0, rsp_valid, rsp_err}, 32'b11);
    chk("pend_htrans", 32'(HTRANS), 0);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("pend_rst", {29'b0, rsp_valid, rsp_err, busy}, 0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Long stall (times out when enabled) and HREADY on the last allowed cycle.
    e = model(1'b0, 32'h400, 2'd2, 0, 120, 1'b0, 32'h77777777);
    do_txn(1'b0, 32'h400, 2'd2, 32'h0, 0, 120, 1'b0, 32'h77777777, 0, 1'b0);
    chk("stall_err", 32'(r_err), 32'(e.err));
    chk("stall_to", 32'(r_to), 32'(e.to));
    chk("stall_rdata", r_rdata, e.rdata);
    chk("stall_lat", r_lat, e.lat);
    chk("stall_bus", r_bad, 0);
    e = model(1'b0, 32'h404, 2'd2, 0, TB_TIMEOUT - 1, 1'b0, 32'h5EED5EED);
    do_txn(1'b0, 32'h404, 2'd2, 32'h0, 0, TB_TIMEOUT - 1, 1'b0, 32'h5EED5EED, 0, 1'b0);
    chk("edge_err", 32'(r_err), 32'(e.err));
    chk("edge_rdata", r_rdata, e.rdata);
    chk("edge_lat", r_lat, e.lat);

    for (int t = 0; t < 40; t++) begin
      logic        w, serr;
      logic [31:0] a, wd, rd;
      logic [1:0]  sz;
      int          aw, dw, rdly;
      w    = 1'($urandom_range(0, 1));
      a    = $urandom & 32'h0000FFFF;
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      rd   = $urandom;
      aw   = $urandom_range(0, 2);
      serr = ($urandom_range(0, 3) == 0);
      dw   = $urandom_range(serr ? 1 : 0, 5);
      rdly = $urandom_range(0, 3);
      e = model(w, a, sz, aw, dw, serr, rd);
      do_txn(w, a, sz, wd, aw, dw, serr, rd, rdly, 1'b1);
      chk($sformatf("rnd%0d_err", t), 32'(r_err), 32'(e.err));
      chk($sformatf("rnd%0d_to", t), 32'(r_to), 32'(e.to));
      chk($sformatf("rnd%0d_rdata", t), r_rdata, e.rdata);
      chk($sformatf("rnd%0d_lat", t), r_lat, e.lat);
      chk($sformatf("rnd%0d_nonseq", t), r_nonseq, e.nonseq);
      chk($sformatf("rnd%0d_bus", t), r_bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
Name: ahb_cmd_master

Overview:
AHB-Lite master that turns a simple command/response handshake into single AHB transfers, one outstanding at a time. It is the initiator counterpart to the team's AHB slave BFMs and memory models. It lets testbench sequencers and small on-chip controllers drive any AHB slave without hand-coding bus phases. It sits between a command source and an AHB decoder/slave.

Parameters:
AWIDTH, 32, width of HADDR and cmd_addr
HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged data)
TIMEOUT, 256, data-phase wait-state limit in cycles (used only with AHBM_TIMEOUT_EN); legal range 2..65535

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  master accepts command this cycle
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  AWIDTH  byte address
cmd_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
cmd_wdata  in  32  write data, already lane-placed by the source
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  transfer failed (HRESP error, misalignment, or timeout)
rsp_timeout  out  1  failure was caused by timeout
busy  out  1  state != IDLE
HADDR  out  AWIDTH  address
HTRANS  out  2  IDLE = 00, NONSEQ = 10 only
HWRITE  out  1  direction
HSIZE  out  3  {1'b0, cmd_size}
HBURST  out  3  constant 000 (SINGLE)
HMASTLOCK  out  1  constant 0
HPROT  out  4  HPROT_VAL
HWDATA  out  32  write data, valid in the data phase
HRDATA  in  32  read data
HREADY  in  1  bus ready, from the interconnect
HRESP  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset values: HTRANS = IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0; cmd_ready = 0; rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0; state = IDLE.
- Reset taken mid-transfer returns to IDLE at the next edge. Any pending response is discarded. HTRANS is IDLE in the cycle after the reset edge.
- All bus outputs and rsp_* come from registers.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the command.
  - Misaligned commands (size 1 with addr[0] = 1; size 2 with addr[1:0] != 0) or size 3 go straight to RESP with rsp_err = 1. No bus activity.
  - Otherwise go to ADDR.
- ADDR:
  - Drive HTRANS = NONSEQ with HADDR, HWRITE, HSIZE.
  - Hold everything until HREADY = 1, then go to DATA.
- DATA:
  - Drive HTRANS = IDLE. HWDATA = latched wdata for writes, 0 for reads.
  - HREADY = 0 with HRESP = 0: wait.
  - HREADY = 0 with HRESP = 1 (first error cycle): keep HTRANS IDLE and wait.
  - HREADY = 1: capture HRDATA (reads only) and HRESP into rsp_err, then go to RESP.
- RESP:
  - rsp_valid = 1, fields stable, until rsp_ready = 1.
  - Then go to IDLE and clear rsp_valid in the same edge.
  - cmd_ready returns in the following cycle, so back-to-back commands have 1 idle cycle between responses.
- Latency: an aligned, zero-wait-state command gives rsp_valid 3 cycles after cmd_valid && cmd_ready (ADDR, DATA, RESP).
- rsp_ready asserted while rsp_valid = 0 is ignored.
- cmd_* changes while cmd_ready = 0 are ignored.

Optional Feature:
AHBM_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on entry to DATA and increments each DATA cycle with HREADY = 0.
  - When it reaches TIMEOUT-1 while HREADY is still 0, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - HTRANS stays IDLE.
  - HREADY = 1 in the same cycle wins over the timeout.
- Undefined: no counter; the master waits indefinitely; rsp_timeout is tied to 0.

Decomposition:
- Package ahb_master_pkg:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ) and HBURST_SINGLE.
  - HSIZE codes (BYTE, HALF, WORD).
  - FSM state encoding (IDLE, ADDR, DATA, RESP).
  - Alignment-check function.
- Sub-module: none. The timeout counter is small enough to stay inline.

Test Plan:
- Word write: addr 0x100, data 0xDEADBEEF, HREADY tied 1 -> NONSEQ in one cycle, HWDATA = 0xDEADBEEF in the next cycle, rsp_valid 3 cycles after accept, rsp_err = 0.
- Read with slave wait states: read 0x104, HREADY low for 3 data-phase cycles, HRDATA = 0x12345678 -> rsp_rdata = 0x12345678; HADDR/HTRANS held correctly through the address phase.
- Two-cycle ERROR response from the slave -> rsp_err = 1, HTRANS never leaves IDLE after the address phase, rsp_rdata = 0.
- Misaligned halfword at 0x101, and size 3 -> rsp_err = 1 with no NONSEQ issued; HTRANS = IDLE throughout.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_* stable and cmd_ready = 0 throughout. Then HRESET pulsed in DATA state -> HTRANS = IDLE and rsp_valid = 0 on the next edge.
- AHBM_TIMEOUT_EN with TIMEOUT = 4 and HREADY held low -> rsp_timeout = 1 and rsp_err = 1 after 4 data-phase cycles. Without the macro the master is still in DATA after 100 cycles.
